// File: rtl/defines_pkg.sv
// defines_pkg: instruction-line fill geometry and fill FSM state encoding
package defines_pkg;
  localparam int LINE_BITS = 1024;
  localparam int QW_BITS = 128;
  localparam int QW_PER_LINE = 8;
  localparam logic [3:0] LAST_QW = 4'(QW_PER_LINE - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fill_state_e;
endpackage

// File: rtl/icache_fill.sv
// icache_fill: fetches one 128-byte line from local store as eight pipelined quadword reads
module icache_fill
  import defines_pkg::*;
#(
  parameter logic [31:0] LS_ADDR_MASK = 32'h0003_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fill_req,
  input  logic [31:0]          fill_pc,
  input  logic                 flush,
  output logic                 ls_req,
  input  logic                 ls_gnt,
  output logic [31:0]          ls_addr,
  input  logic [QW_BITS-1:0]   ls_rdata,
  output logic [LINE_BITS-1:0] cache_line,
  output logic                 cache_wr,
  output logic [24:0]          cache_tag,
  output logic                 fill_busy
);
  fill_state_e state, state_nxt;
  logic [31:0] base;
  logic [3:0] iss, rcv;
  logic rd_vld, accept, abort, grant;
  assign accept = fill_req && (state == IDLE || flush);
  assign abort = flush && state != IDLE;
  assign grant = ls_req && ls_gnt;
  assign ls_addr = (base + {25'b0, iss[2:0], 4'b0}) & LS_ADDR_MASK;
  assign cache_tag = base[31:7];
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next state and per-state outputs; a new request or a flush overrides normal sequencing
  always_comb begin
    state_nxt = state;
    ls_req = 1'b0;
    cache_wr = 1'b0;
    fill_busy = state != IDLE;
    case (state)
      ISSUE: begin
        ls_req = 1'b1;
        state_nxt = (ls_gnt && iss == LAST_QW) ? DRAIN : ISSUE;
      end
      DRAIN: state_nxt = (rd_vld && rcv == LAST_QW) ? DONE : DRAIN;
      DONE: begin
        cache_wr = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    state_nxt = accept ? ISSUE : abort ? IDLE : state_nxt;
  end
  // line bookkeeping; quadword 0 lands in the most significant 128 bits of the line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      base <= '0;
      iss <= '0;
      rcv <= '0;
      rd_vld <= 1'b0;
      cache_line <= '0;
    end else if (accept) begin
      base <= fill_pc & ~32'h7F;
      iss <= '0;
      rcv <= '0;
      rd_vld <= 1'b0;
      cache_line <= '0;
    end else begin
      rd_vld <= grant && !flush;
      if (grant) iss <= iss + 4'd1;
      if (rd_vld && !abort) begin
        cache_line[{~rcv[2:0], 7'b0} +: QW_BITS] <= ls_rdata;
        rcv <= rcv + 4'd1;
      end
    end
endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: scoreboard bench for icache_fill addressing, assembly, flush and reset
module tb_icache_fill;
  logic clk = 1'b0;
  logic rst, fill_req, flush, ls_gnt, ls_req, cache_wr, fill_busy;
  logic [31:0] fill_pc, ls_addr;
  logic [127:0] ls_rdata;
  logic [1023:0] cache_line, last_line;
  logic [24:0] cache_tag, last_tag;
  logic [31:0] addr_q[$];
  logic [1023:0] line_q[$];
  logic [24:0] tag_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  icache_fill dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .fill_pc(fill_pc), .flush(flush),
    .ls_req(ls_req), .ls_gnt(ls_gnt), .ls_addr(ls_addr), .ls_rdata(ls_rdata),
    .cache_line(cache_line), .cache_wr(cache_wr), .cache_tag(cache_tag), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEAD_0000, ~a, a + 32'h0101_0101, {a[15:0], a[31:16]}};
  endfunction

  task automatic push_fill(input logic [31:0] pc);
    logic [31:0] b, a;
    logic [1023:0] l;
    b = pc & ~32'h7F;
    for (int i = 0; i < 8; i++) begin
      a = (b + 32'(16 * i)) & 32'h0003_FFFF;
      addr_q.push_back(a);
      l[1023 - 128 * i -: 128] = pat(a);
    end
    line_q.push_back(l);
    tag_q.push_back(b[31:7]);
  endtask

  task automatic run_fill(input string name, input logic [31:0] pc, input logic [31:0] pc2,
                          input int mode, input int flush_at, input int req2_at, input int n, input int exp_wr);
    int wr_c;
    logic pend, bz;
    logic [31:0] pend_a;
    logic [1023:0] l;
    logic [24:0] t;
    wr_c = -1;
    pend = 1'b0;
    pend_a = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fill_req = (c == 0) || (c == req2_at);
      fill_pc = (c == 0) ? pc : pc2;
      flush = (c == flush_at);
      ls_gnt = (mode == 0) || (c % 2 == 0);
      ls_rdata = pend ? pat(pend_a) : {$urandom, $urandom, $urandom, $urandom};
      #1;
      bz = line_q.size() != 0;
      n_cmp++;
      if (fill_busy !== bz) begin
        n_bad++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, fill_busy, bz);
      end
      pend = 1'b0;
      if (ls_req) begin
        n_cmp++;
        if (addr_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s spurious ls_req cycle %0d: got 1 want 0", name, c);
        end else begin
          if (ls_addr !== addr_q[0]) begin
            n_bad++;
            $display("FAIL %s ls_addr cycle %0d: got %h want %h", name, c, ls_addr, addr_q[0]);
          end
          if (ls_gnt) begin
            pend = 1'b1;
            pend_a = addr_q.pop_front();
          end
        end
      end
      if (cache_wr) begin
        n_cmp++;
        wr_c = c;
        if (line_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s unexpected cache_wr cycle %0d", name, c);
        end else begin
          l = line_q.pop_front();
          t = tag_q.pop_front();
          last_line = l;
          last_tag = t;
          if (cache_line !== l || cache_tag !== t) begin
            n_bad++;
            $display("FAIL %s line/tag cycle %0d: got tag %h line %h want tag %h line %h", name, c, cache_tag, cache_line[1023:896], t, l[1023:896]);
          end
        end
      end
      if (flush) begin
        addr_q.delete();
        line_q.delete();
        tag_q.delete();
        pend = 1'b0;
      end
      if (c == 0) push_fill(pc);
      else if (c == req2_at && c == flush_at) push_fill(pc2);
    end
    @(negedge clk);
    fill_req = 1'b0;
    flush = 1'b0;
    #1;
    n_cmp++;
    if (wr_c != exp_wr) begin
      n_bad++;
      $display("FAIL %s cache_wr cycle: got %0d want %0d", name, wr_c, exp_wr);
    end
    if (wr_c >= 0) begin
      n_cmp++;
      if (cache_line !== last_line || cache_tag !== last_tag) begin
        n_bad++;
        $display("FAIL %s hold: got tag %h want %h", name, cache_tag, last_tag);
      end
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({ls_req, cache_wr, fill_busy} !== 3'b000 || ls_addr !== '0 || cache_line !== '0 || cache_tag !== '0) begin
      n_bad++;
      $display("FAIL %s outputs: got req %b wr %b busy %b addr %h tag %h line_nz %b want all zero",
               name, ls_req, cache_wr, fill_busy, ls_addr, cache_tag, |cache_line);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    fill_req = 1'b0;
    flush = 1'b0;
    ls_gnt = 1'b0;
    fill_pc = '0;
    ls_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_flush;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      flush = 1'b1;
      fill_req = 1'b0;
      #1;
      n_cmp++;
      if (ls_req !== 1'b0 || fill_busy !== 1'b0 || cache_wr !== 1'b0 || cache_tag !== last_tag || cache_line !== last_line) begin
        n_bad++;
        $display("FAIL idle_flush cycle %0d: got req %b busy %b wr %b tag %h want 0 0 0 %h", c, ls_req, fill_busy, cache_wr, cache_tag, last_tag);
      end
    end
    flush = 1'b0;
    run_fill("idle_flush_req", 32'h0000_0A00, 32'h0000_0A00, 0, 0, 0, 14, 10);
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fill_req = (c == 0);
      fill_pc = 32'h0000_3000;
      ls_gnt = 1'b1;
      if (c == 4) rst = 1'b0;
      if (c == 6) rst = 1'b1;
      #1;
      if (c == 4) check_zero("reset_mid_async");
      if (c >= 6) begin
        n_cmp++;
        if (cache_wr !== 1'b0 || fill_busy !== 1'b0 || ls_req !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_mid after release cycle %0d: got wr %b busy %b req %b want 0", c, cache_wr, fill_busy, ls_req);
        end
      end
    end
    fill_req = 1'b0;
    run_fill("reset_mid_refill", 32'h0000_4000, 32'h0, 0, -1, -1, 14, 10);
  endtask

  initial begin
    last_line = '0;
    last_tag = '0;
    test_reset;
    run_fill("basic", 32'h0000_1234, 32'h0, 0, -1, -1, 14, 10);
    run_fill("back_to_back", 32'h0000_5678, 32'h0, 0, -1, -1, 13, 10);
    run_fill("mask_wrap", 32'h0007_FFC0, 32'h0, 0, -1, -1, 13, 10);
    run_fill("gnt_toggle", 32'h0000_1234, 32'h0, 1, -1, -1, 22, 18);
    run_fill("flush", 32'h0000_1000, 32'h0, 0, 4, -1, 10, -1);
    run_fill("restart", 32'h0000_1000, 32'h0000_2000, 0, 5, 5, 20, 15);
    run_fill("mask", 32'h0004_0080, 32'h0, 0, -1, -1, 14, 10);
    run_fill("ignore", 32'h0000_6000, 32'h0000_7000, 0, -1, 4, 14, 10);
    run_fill("flush_done", 32'h0000_8000, 32'h0, 0, 10, -1, 14, -1);
    run_fill("refill", 32'h0000_9100, 32'h0, 1, -1, -1, 22, 18);
    test_idle_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
